// File: rtl/mem_ctrl_multiport.sv
// Byte-serial memory controller: round-robin arbitration of NUM_PORTS requesters onto an
// 8-bit RAM/IO bus, 1/2/4-byte little-endian transfers, UART back-pressure and read flush.
module mem_ctrl_multiport #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        clr,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS-1:0]        req_wr,
    input  logic [2*NUM_PORTS-1:0]      req_size,
    input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
    input  logic [32*NUM_PORTS-1:0]     req_wdata,
    output logic [NUM_PORTS-1:0]        done,
    output logic [31:0]                 rdata,
    input  logic [7:0]                  mem_din,
    output logic [7:0]                  mem_dout,
    output logic [31:0]                 mem_a,
    output logic                        mem_wr,
    input  logic                        io_buffer_full
);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, IOWAIT} state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       rr_q, rr_d;
    logic [PTR_W-1:0]       port_q, port_d;
    logic [NUM_PORTS-1:0]   done_q, done_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [31:0]            mem_a_q, mem_a_d;
    logic [7:0]             mem_dout_q, mem_dout_d;
    logic                   mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            rbuf_q, rbuf_d;
    logic [2:0]             len_q, len_d;
    logic [2:0]             k_q, k_d;
    logic                   io_q, io_d;

    logic [NUM_PORTS-1:0]   eligible;
    logic                   grant_found;
    logic [PTR_W-1:0]       grant_idx;
    logic                   sel_wr;
    logic [1:0]             sel_size;
    logic [ADDR_W-1:0]      sel_addr;
    logic [31:0]            sel_wdata;
    logic [2:0]             sel_len;
    logic [ADDR_W-1:0]      addr_k;
    logic [31:0]            rbuf_merged;

    // Round-robin: first eligible index at or above the pointer, else first eligible overall.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        eligible    = req_valid & ~done_q & ~({NUM_PORTS{clr}} & ~req_wr);
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!grant_found && eligible[i] && i >= int'(rr_q)) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!grant_found && eligible[i]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(i);
            end
        end

        sel_wr    = 1'b0;
        sel_size  = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (int'(grant_idx) == i) begin
                sel_wr    = req_wr[i];
                sel_size  = req_size[2*i +: 2];
                sel_addr  = req_addr[ADDR_W*i +: ADDR_W];
                sel_wdata = req_wdata[32*i +: 32];
            end
        end

        case (sel_size)
            2'd0:    sel_len = 3'd1;
            2'd1:    sel_len = 3'd2;
            default: sel_len = 3'd4;
        endcase
    end

    always_comb begin
        addr_k      = addr_q + ADDR_W'(k_q);
        rbuf_merged = rbuf_q | (32'(mem_din) << {k_q - 3'd1, 3'b000});

        state_d    = state_q;
        rr_d       = rr_q;
        port_d     = port_q;
        done_d     = done_q;
        rdata_d    = rdata_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        len_d      = len_q;
        k_d        = k_q;
        io_d       = io_q;

        if (rdy) begin
            done_d   = '0;
            mem_a_d  = '0;
            mem_wr_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        port_d  = grant_idx;
                        rr_d    = (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;
                        addr_d  = sel_addr;
                        wdata_d = sel_wdata;
                        len_d   = sel_len;
                        io_d    = (sel_addr[17:16] == 2'b11);
                        rbuf_d  = '0;
                        if (!sel_wr) begin
                            state_d = READ;
                            k_d     = 3'd1;
                            mem_a_d = 32'(sel_addr);
                        end else if (sel_addr[17:16] == 2'b11 && io_buffer_full) begin
                            state_d = IOWAIT;
                            k_d     = 3'd0;
                        end else begin
                            state_d    = WRITE;
                            k_d        = 3'd1;
                            mem_a_d    = 32'(sel_addr);
                            mem_dout_d = sel_wdata[7:0];
                            mem_wr_d   = 1'b1;
                        end
                    end
                end
                READ: begin
                    if (clr) begin
                        state_d = IDLE;
                    end else if (k_q == len_q) begin
                        done_d[port_q] = 1'b1;
                        rdata_d        = rbuf_merged;
                        state_d        = IDLE;
                    end else begin
                        rbuf_d  = rbuf_merged;
                        mem_a_d = 32'(addr_k);
                        k_d     = k_q + 3'd1;
                    end
                end
                WRITE: begin
                    if (k_q == len_q) begin
                        done_d[port_q] = 1'b1;
                        state_d        = IDLE;
                    end else if (io_q && io_buffer_full) begin
                        state_d = IOWAIT;
                    end else begin
                        mem_a_d    = 32'(addr_k);
                        mem_dout_d = 8'(wdata_q >> {k_q, 3'b000});
                        mem_wr_d   = 1'b1;
                        k_d        = k_q + 3'd1;
                    end
                end
                IOWAIT: begin
                    // Stores are never torn by a flush; only the UART decides when a byte goes.
                    if (!io_buffer_full) begin
                        state_d    = WRITE;
                        mem_a_d    = 32'(addr_k);
                        mem_dout_d = 8'(wdata_q >> {k_q, 3'b000});
                        mem_wr_d   = 1'b1;
                        k_d        = k_q + 3'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            port_q     <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            len_q      <= '0;
            k_q        <= '0;
            io_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            rr_q       <= rr_d;
            port_q     <= port_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            len_q      <= len_d;
            k_q        <= k_d;
            io_q       <= io_d;
        end
    end

    assign done     = done_q;
    assign rdata    = rdata_q;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl_multiport.sv
// Directed bench for mem_ctrl_multiport: byte RAM model, write log, hand-computed expectations.
module tb_mem_ctrl_multiport;
    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clr;
    logic [1:0]  req_valid;
    logic [1:0]  req_wr;
    logic [3:0]  req_size;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  done;
    logic [31:0] rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    logic [7:0]  ram [0:262143];
    logic [31:0] log_a[$];
    logic [7:0]  log_d[$];

    int n_vec = 0;
    int n_bad = 0;

    mem_ctrl_multiport #(.NUM_PORTS(2), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .clr            (clr),
        .req_valid      (req_valid),
        .req_wr         (req_wr),
        .req_size       (req_size),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .done           (done),
        .rdata          (rdata),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always #5 clk = ~clk;

    assign mem_din = ram[mem_a[17:0]];

    always @(posedge clk) begin
        if (mem_wr) begin
            ram[mem_a[17:0]] <= mem_dout;
            log_a.push_back(mem_a);
            log_d.push_back(mem_dout);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d);
        req_wr[p]              = wr;
        req_size[2*p +: 2]     = sz;
        req_addr[32*p +: 32]   = a;
        req_wdata[32*p +: 32]  = d;
        req_valid[p]           = 1'b1;
    endtask

    task automatic wait_done(input int max_cyc, output logic [1:0] seen, output int cyc);
        seen = '0;
        cyc  = 0;
        while (cyc < max_cyc && seen == 2'b00) begin
            tick();
            cyc++;
            seen = done;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] seen;
        int         cyc;
        int         order[4];
        logic [31:0] rd[4];
        int         n;
        int         wr_cnt;
        logic [1:0] done_acc;

        rst = 1'b1; rdy = 1'b1; clr = 1'b0; io_buffer_full = 1'b0;
        req_valid = '0; req_wr = '0; req_size = '0; req_addr = '0; req_wdata = '0;
        ram[18'h100] = 8'h11; ram[18'h101] = 8'h22; ram[18'h102] = 8'h33; ram[18'h103] = 8'h44;
        ram[18'h010] = 8'hA5; ram[18'h020] = 8'h5A;
        tick(); tick();
        rst = 1'b0;
        tick();

        check("rst_done", 32'(done), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_dout", 32'(mem_dout), 32'h0);
        check("rst_mem_wr", 32'(mem_wr), 32'h0);

        // P0 4-byte read at 0x100: address walks E0..E3, done at E4.
        set_req(0, 1'b0, 2'd2, 32'h100, 32'h0);
        tick(); check("rd4_a_e0", mem_a, 32'h100); check("rd4_done_e0", 32'(done), 32'h0);
        tick(); check("rd4_a_e1", mem_a, 32'h101);
        tick(); check("rd4_a_e2", mem_a, 32'h102);
        tick(); check("rd4_a_e3", mem_a, 32'h103); check("rd4_done_e3", 32'(done), 32'h0);
        tick(); check("rd4_done_e4", 32'(done), 32'h1); check("rd4_rdata", rdata, 32'h44332211);
        check("rd4_a_e4", mem_a, 32'h0);
        req_valid = '0;
        tick(); check("rd4_done_pulse", 32'(done), 32'h0);

        // P1 2-byte write 0xBEEF at 0x2000 (pointer is 1 after the port-0 grant).
        log_a.delete(); log_d.delete();
        set_req(1, 1'b1, 2'd1, 32'h2000, 32'h0000BEEF);
        tick(); check("wr2_wr_e0", 32'(mem_wr), 32'h1); check("wr2_a_e0", mem_a, 32'h2000);
        check("wr2_d_e0", 32'(mem_dout), 32'hEF);
        tick(); check("wr2_wr_e1", 32'(mem_wr), 32'h1); check("wr2_a_e1", mem_a, 32'h2001);
        check("wr2_d_e1", 32'(mem_dout), 32'hBE);
        tick(); check("wr2_done_e2", 32'(done), 32'h2); check("wr2_wr_e2", 32'(mem_wr), 32'h0);
        req_valid = '0;
        check("wr2_nwrites", 32'(log_a.size()), 32'd2);
        check("wr2_ram", {16'h0, ram[18'h2001], ram[18'h2000]}, 32'h0000BEEF);
        tick();

        // Both ports read continuously; pointer is back at 0, so grants go 0,1,0,1.
        set_req(0, 1'b0, 2'd0, 32'h10, 32'h0);
        set_req(1, 1'b0, 2'd0, 32'h20, 32'h0);
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            if (done != 2'b00) begin
                order[n] = (done == 2'b01) ? 0 : (done == 2'b10) ? 1 : 9;
                rd[n]    = rdata;
                n++;
                if (n == 4) req_valid = '0;
            end
        end
        check("rr_count", 32'(n), 32'd4);
        for (int i = 0; i < n; i++) begin
            check($sformatf("rr_port%0d", i), 32'(order[i]), 32'(i % 2));
            check($sformatf("rr_rdata%0d", i), rd[i], (i % 2 == 0) ? 32'hA5 : 32'h5A);
        end
        tick();

        // IO 1-byte write held off by a full UART for 5 cycles.
        log_a.delete(); log_d.delete();
        io_buffer_full = 1'b1;
        set_req(0, 1'b1, 2'd0, 32'h30000, 32'h41);
        wr_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (mem_wr) wr_cnt++;
        end
        check("io_stall_wr", 32'(wr_cnt), 32'd0);
        check("io_stall_done", 32'(done), 32'h0);
        io_buffer_full = 1'b0;
        wait_done(10, seen, cyc);
        req_valid = '0;
        check("io_done", 32'(seen), 32'h1);
        check("io_nwrites", 32'(log_a.size()), 32'd1);
        if (log_a.size() > 0) begin
            check("io_addr", log_a[0], 32'h30000);
            check("io_data", 32'(log_d[0]), 32'h41);
        end
        tick();

        // Flush at E2 of a 4-byte read: no done, rdata keeps the last completed read.
        set_req(0, 1'b0, 2'd2, 32'h100, 32'h0);
        tick(); tick();
        clr = 1'b1;
        tick();
        check("clr_rd_a", mem_a, 32'h0);
        clr = 1'b0; req_valid = '0;
        done_acc = done;
        for (int c = 0; c < 4; c++) begin
            tick();
            done_acc |= done;
        end
        check("clr_rd_nodone", 32'(done_acc), 32'h0);
        check("clr_rd_rdata", rdata, 32'h5A);

        // Flush held through a 4-byte write: the store still completes.
        log_a.delete(); log_d.delete();
        clr = 1'b1;
        set_req(0, 1'b1, 2'd2, 32'h3000, 32'hDDCCBBAA);
        wait_done(20, seen, cyc);
        clr = 1'b0; req_valid = '0;
        check("clr_wr_done", 32'(seen), 32'h1);
        check("clr_wr_nwrites", 32'(log_a.size()), 32'd4);
        check("clr_wr_ram", {ram[18'h3003], ram[18'h3002], ram[18'h3001], ram[18'h3000]},
              32'hDDCCBBAA);
        tick();

        // rdy low 3 cycles in the middle of a 4-byte write.
        log_a.delete(); log_d.delete();
        set_req(1, 1'b1, 2'd2, 32'h4000, 32'h87654321);
        tick(); tick();
        rdy = 1'b0;
        #1;
        check("rdy_wr_gated", 32'(mem_wr), 32'h0);
        tick(); tick(); tick();
        check("rdy_frozen_a", mem_a, 32'h4001);
        check("rdy_frozen_done", 32'(done), 32'h0);
        rdy = 1'b1;
        wait_done(20, seen, cyc);
        req_valid = '0;
        check("rdy_done", 32'(seen), 32'h2);
        check("rdy_nwrites", 32'(log_a.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_a.size(); i++) begin
            check($sformatf("rdy_a%0d", i), log_a[i], 32'h4000 + 32'(i));
            check($sformatf("rdy_d%0d", i), 32'(log_d[i]), (32'h87654321 >> (8 * i)) & 32'hFF);
        end
        tick();

        // Reset during a 4-byte read: everything returns to zero, no done.
        set_req(0, 1'b0, 2'd2, 32'h100, 32'h0);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("mrst_mem_a", mem_a, 32'h0);
        check("mrst_done", 32'(done), 32'h0);
        check("mrst_rdata", rdata, 32'h0);
        check("mrst_mem_dout", 32'(mem_dout), 32'h0);
        check("mrst_mem_wr", 32'(mem_wr), 32'h0);
        req_valid = '0;
        tick();
        rst = 1'b0;
        done_acc = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            done_acc |= done;
        end
        check("mrst_nodone", 32'(done_acc), 32'h0);

        // 2-byte read after reset: done exactly 2 cycles after the grant edge.
        set_req(0, 1'b0, 2'd1, 32'h102, 32'h0);
        wait_done(10, seen, cyc);
        req_valid = '0;
        check("rd2_done", 32'(seen), 32'h1);
        check("rd2_latency", 32'(cyc), 32'd3);
        check("rd2_rdata", rdata, 32'h00004433);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
